// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life generation engine.
package life_pkg;

    // FSM encoding is visible on state_out, so the values are fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAUSE = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } life_state_t;

    // Flat bit position of cell (r,c) in a row-major grid vector.
    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_next.sv
// Combinational successor-generation logic for a ROWS x COLS Life grid.
// Each cell looks at its 8 neighbours; WRAP selects toroidal or dead edges.
module life_next
    import life_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int COLS = 16,
    parameter int WRAP = 1
) (
    input  logic [ROWS*COLS-1:0] grid,
    output logic [ROWS*COLS-1:0] next_grid
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nb;
            logic [3:0] n;

            // Neighbour k: k=0..2 row above, k=3/4 same row, k=5..7 row below.
            for (genvar k = 0; k < 8; k++) begin : g_nb
                localparam int DR     = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
                localparam int DC     = (k < 3) ? (k - 1) :
                                        ((k == 3) ? -1 : ((k == 4) ? 1 : (k - 6)));
                localparam int NR     = (r + DR + ROWS) % ROWS;
                localparam int NC     = (c + DC + COLS) % COLS;
                localparam bit INSIDE = (r + DR >= 0) && (r + DR < ROWS) &&
                                        (c + DC >= 0) && (c + DC < COLS);
                assign nb[k] = (WRAP != 0 || INSIDE) ? grid[cell_idx(NR, NC, COLS)] : 1'b0;
            end

            // Population count of the eight neighbours.
            always_comb begin
                n = '0;
                for (int k = 0; k < 8; k++) begin
                    n = n + {3'b000, nb[k]};
                end
            end

            // Birth on exactly 3, survival on 2 or 3.
            assign next_grid[cell_idx(r, c, COLS)] =
                (n == 4'd3) | (grid[cell_idx(r, c, COLS)] & (n == 4'd2));
        end
    end

endmodule

// File: rtl/life_engine.sv
// Game-of-Life generation engine: grid register, control FSM,
// saturating generation counter, update pulse and still/extinct flags.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | grid cleared or never seeded; only clear/load act
// PAUSE | seeded, frozen; step advances one generation, run starts
// RUN   | advances one generation per tick until paused or stable
// HALT  | grid reached a still life; frozen until load/clear
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS           = 16,
    parameter int COLS           = 16,
    parameter int WRAP           = 1,
    parameter int CW             = 16,
    parameter int STOP_ON_STABLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] seed,
    input  logic                 run,
    input  logic                 pause,
    input  logic                 step,
    input  logic                 tick,
    output logic [ROWS*COLS-1:0] gen_out,
    output logic [CW-1:0]        gen_count,
    output logic                 gen_pulse,
    output logic [1:0]           state_out,
    output logic                 stable,
    output logic                 extinct
);

    life_state_t          state;
    life_state_t          state_nxt;
    logic                 do_update;
    logic [ROWS*COLS-1:0] next_grid;

    life_next #(
        .ROWS (ROWS),
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_next (
        .grid      (gen_out),
        .next_grid (next_grid)
    );

    assign stable    = (next_grid == gen_out);
    assign extinct   = (gen_out == '0);
    assign state_out = state;

    // Command decode: clear > load > pause > step > run, gated by state.
    always_comb begin
        state_nxt = state;
        do_update = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else if (load) begin
            state_nxt = PAUSE;
        end else begin
            case (state)
                PAUSE: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (step) begin
                        do_update = 1'b1;
                    end else if (run) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        // A still grid would never change again, so stop instead of updating.
                        if (stable && (STOP_ON_STABLE != 0)) begin
                            state_nxt = HALT;
                        end else begin
                            do_update = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // Grid, counter, pulse and state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gen_out   <= '0;
            gen_count <= '0;
            gen_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            gen_pulse <= do_update;
            if (clear) begin
                gen_out   <= '0;
                gen_count <= '0;
            end else if (load) begin
                gen_out   <= seed;
                gen_count <= '0;
            end else if (do_update) begin
                gen_out <= next_grid;
                // Saturate so a long run never wraps back to a small count.
                if (gen_count != '1) begin
                    gen_count <= gen_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Scoreboard bench: two 8x8 engines (toroidal/16-bit counter and
// dead-edge/3-bit counter) share one stimulus stream; a behavioural
// Life model predicts each cycle's outputs, a monitor compares them.
module tb_life_engine;
    localparam int R = 8;
    localparam int C = 8;
    localparam int N = R * C;

    logic         clk = 1'b0;
    logic         reset = 1'b1, clear = 1'b0, load = 1'b0;
    logic         run = 1'b0, pause = 1'b0, step = 1'b0, tick = 1'b0;
    logic [N-1:0] seed = '0;

    logic [N-1:0] go0, go1;
    logic [15:0]  cnt0;
    logic [2:0]   cnt1;
    logic         gp0, gp1, st0, st1, ex0, ex1;
    logic [1:0]   so0, so1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    life_engine #(.ROWS(R), .COLS(C), .WRAP(1), .CW(16), .STOP_ON_STABLE(1)) dut_w (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
        .run(run), .pause(pause), .step(step), .tick(tick),
        .gen_out(go0), .gen_count(cnt0), .gen_pulse(gp0), .state_out(so0),
        .stable(st0), .extinct(ex0));

    life_engine #(.ROWS(R), .COLS(C), .WRAP(0), .CW(3), .STOP_ON_STABLE(1)) dut_d (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .seed(seed),
        .run(run), .pause(pause), .step(step), .tick(tick),
        .gen_out(go1), .gen_count(cnt1), .gen_pulse(gp1), .state_out(so1),
        .stable(st1), .extinct(ex1));

    typedef struct {
        int           tgt;
        int           inst;
        logic [N-1:0] g;
        int           cnt;
        int           st;
        bit           pulse;
        bit           stab;
        bit           ext;
    } exp_t;

    exp_t q[$];

    // Reference model state, one slot per engine instance.
    logic [N-1:0] m_grid[2];
    int           m_cnt[2];
    int           m_st[2];
    bit           m_pulse[2];
    int           cnt_max[2] = '{65535, 7};
    bit           wrap_of[2] = '{1'b1, 1'b0};

    // Conway's rule on a row-major 8x8 grid.
    function automatic logic [N-1:0] ref_next(input logic [N-1:0] g, input bit wrap);
        logic [N-1:0] o;
        int n, rr, cc;
        o = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (wrap) begin
                                rr = (rr + R) % R;
                                cc = (cc + C) % C;
                            end
                            if (rr >= 0 && rr < R && cc >= 0 && cc < C && g[rr*C+cc])
                                n++;
                        end
                    end
                end
                if (g[r*C+c]) o[r*C+c] = (n == 2 || n == 3);
                else          o[r*C+c] = (n == 3);
            end
        end
        return o;
    endfunction

    task automatic model_step(input int i);
        logic [N-1:0] nx;
        bit upd;
        nx  = ref_next(m_grid[i], wrap_of[i]);
        upd = 1'b0;
        if (reset) begin
            m_grid[i] = '0; m_cnt[i] = 0; m_st[i] = 0;
        end else if (clear) begin
            m_grid[i] = '0; m_cnt[i] = 0; m_st[i] = 0;
        end else if (load) begin
            m_grid[i] = seed; m_cnt[i] = 0; m_st[i] = 1;
        end else if (m_st[i] == 1) begin
            if (!pause && step) upd = 1'b1;
            else if (!pause && run) m_st[i] = 2;
        end else if (m_st[i] == 2) begin
            if (pause) m_st[i] = 1;
            else if (tick) begin
                if (nx == m_grid[i]) m_st[i] = 3;
                else upd = 1'b1;
            end
        end
        if (upd) begin
            m_grid[i] = nx;
            if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
        end
        m_pulse[i] = upd;
    endtask

    // Apply one cycle of commands and queue the predicted outputs.
    task automatic drive(input bit rs, input bit cl, input bit ld, input bit ru,
                         input bit pa, input bit stp, input bit tk, input logic [N-1:0] sd);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rs; clear = cl; load = ld; run = ru;
        pause = pa; step = stp; tick = tk; seed = sd;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            e.tgt   = cyc + 1;
            e.inst  = i;
            e.g     = m_grid[i];
            e.cnt   = m_cnt[i];
            e.st    = m_st[i];
            e.pulse = m_pulse[i];
            e.stab  = (ref_next(m_grid[i], wrap_of[i]) == m_grid[i]);
            e.ext   = (m_grid[i] == '0);
            q.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input int inst, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d got %h exp %h", nm, inst, cyc, got, exp);
        end
    endtask

    // Monitor: compare every output whose predicted cycle has arrived.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (q.size() > 0 && q[0].tgt <= cyc) begin
                e = q.pop_front();
                if (e.inst == 0) begin
                    chk("gen_out", 0, go0, e.g);
                    chk("gen_count", 0, N'(cnt0), N'(e.cnt));
                    chk("gen_pulse", 0, N'(gp0), N'(e.pulse));
                    chk("state", 0, N'(so0), N'(e.st));
                    chk("stable", 0, N'(st0), N'(e.stab));
                    chk("extinct", 0, N'(ex0), N'(e.ext));
                end else begin
                    chk("gen_out", 1, go1, e.g);
                    chk("gen_count", 1, N'(cnt1), N'(e.cnt));
                    chk("gen_pulse", 1, N'(gp1), N'(e.pulse));
                    chk("state", 1, N'(so1), N'(e.st));
                    chk("stable", 1, N'(st1), N'(e.stab));
                    chk("extinct", 1, N'(ex1), N'(e.ext));
                end
            end
        end
    end

    initial begin
        logic [N-1:0] blinker, block, glider, rnd;
        blinker = '0; blinker[44] = 1'b1; blinker[45] = 1'b1; blinker[46] = 1'b1;
        block   = '0; block[27] = 1'b1; block[28] = 1'b1; block[35] = 1'b1; block[36] = 1'b1;
        glider  = '0; glider[1] = 1'b1; glider[10] = 1'b1; glider[16] = 1'b1;
        glider[17] = 1'b1; glider[18] = 1'b1;

        // reset, then commands in IDLE must be ignored
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 1, 0, 1, 1, '0);
        drive(0, 0, 0, 0, 1, 0, 1, '0);

        // blinker: 10 ticks in RUN (3-bit counter saturates at 7)
        drive(0, 0, 1, 0, 0, 0, 0, blinker);
        drive(0, 0, 0, 1, 0, 0, 0, '0);
        for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0, 1, '0);
        // step ignored in RUN, tick low holds
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0, 1, 0, '0);
        // pause beats tick; pause+step in PAUSE does nothing; step+run steps only
        drive(0, 0, 0, 0, 1, 0, 1, '0);
        drive(0, 0, 0, 0, 1, 1, 0, '0);
        drive(0, 0, 0, 1, 0, 1, 0, '0);
        drive(0, 0, 0, 0, 0, 0, 0, '0);

        // block still life halts on first tick; further commands ignored
        drive(0, 0, 1, 0, 0, 0, 0, block);
        drive(0, 0, 0, 1, 0, 0, 0, '0);
        drive(0, 0, 0, 0, 0, 0, 1, '0);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 1, k == 1, 1, 1, '0);

        // glider: 32 held steps, then run (dead-edge copy settles and halts)
        drive(0, 0, 1, 0, 0, 0, 0, glider);
        for (int k = 0; k < 32; k++) drive(0, 0, 0, 0, 0, 1, 0, '0);
        drive(0, 0, 0, 1, 0, 0, 0, '0);
        for (int k = 0; k < 30; k++) drive(0, 0, 0, 0, 0, 0, 1, '0);

        // load and clear together: clear wins
        drive(0, 1, 1, 1, 0, 0, 1, blinker);
        drive(0, 0, 0, 1, 0, 1, 1, '0);

        // extinct grid in RUN halts on first tick
        drive(0, 0, 1, 0, 0, 0, 0, '0);
        drive(0, 0, 0, 1, 0, 0, 1, '0);
        drive(0, 0, 0, 0, 0, 0, 1, '0);

        // reset mid-RUN after 4 generations, with commands asserted
        drive(0, 0, 1, 0, 0, 0, 0, blinker);
        drive(0, 0, 0, 1, 0, 0, 0, '0);
        for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 0, 0, 1, '0);
        drive(1, 0, 1, 1, 0, 1, 1, glider);
        drive(0, 0, 0, 0, 0, 0, 0, '0);

        // randomized command mix
        for (int k = 0; k < 400; k++) begin
            rnd = {$urandom, $urandom} & {$urandom, $urandom};
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 0, rnd);
        end

        drive(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Game-of-Life generation engine for an ROWS x COLS grid.
- Successor to the fixed 16x16 start/pause generator. Adds:
  - toroidal or dead-edge boundary mode
  - single-step
  - external rate tick
  - generation counter
  - still-life and extinction detection, with an optional auto-halt
- Sits between the seed/control logic and the display scanner; gen_out feeds the display directly.

Parameters:
- ROWS, 16, grid rows (>=3)
- COLS, 16, grid columns (>=3)
- WRAP, 1, 1 = toroidal neighbours; 0 = cells outside the grid are dead
- CW, 16, generation counter width
- STOP_ON_STABLE, 1, 1 = RUN moves to HALT when next grid equals current grid

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  zero the grid and return to IDLE
- load  in  1  capture seed into the grid
- seed  in  ROWS*COLS  initial pattern; cell (r,c) = bit r*COLS+c
- run  in  1  start or resume continuous evolution
- pause  in  1  suspend evolution
- step  in  1  advance exactly one generation while paused
- tick  in  1  rate enable; RUN advances only on cycles with tick=1
- gen_out  out  ROWS*COLS  current grid, registered
- gen_count  out  CW  generations computed since last load/clear; saturating
- gen_pulse  out  1  one-cycle pulse, registered, on the cycle after each grid update
- state_out  out  2  current FSM state encoding
- stable  out  1  combinational: next grid == gen_out
- extinct  out  1  combinational: gen_out == 0

Behaviour:
- Reset values:
  - gen_out = 0, gen_count = 0, gen_pulse = 0, state = IDLE
  - stable = 1 and extinct = 1 follow from an empty grid
- Next-state rule, per cell with n = live neighbours (8-neighbourhood):
  - live cell survives iff n = 2 or 3
  - dead cell is born iff n = 3
  - WRAP=1: indices wrap modulo ROWS/COLS; WRAP=0: out-of-range neighbours count as 0
- States: IDLE=0, PAUSE=1, RUN=2, HALT=3.
- Command priority per cycle: reset > clear > load > pause > step > run.
  - Lower-priority commands in the same cycle are ignored.
- clear, any state: grid <= 0, gen_count <= 0, state <= IDLE.
- load, any state: grid <= seed, gen_count <= 0, state <= PAUSE.
  - No generation is computed in the load cycle.
- IDLE: only clear and load act; run, step and pause are ignored.
- PAUSE:
  - run -> RUN.
  - step -> one update (grid <= next, gen_count++) and stay in PAUSE; tick is not required.
  - A held step advances once per cycle.
- RUN:
  - pause -> PAUSE with no update that cycle.
  - On tick=1 with stable=1 and STOP_ON_STABLE=1 -> HALT; no update, count unchanged.
  - Otherwise, on tick=1: update grid, gen_count++.
  - tick=0: hold grid.
  - step is ignored in RUN.
- HALT: grid frozen; run, step, pause and tick are ignored. Exit via load (-> PAUSE) or clear (-> IDLE).
- Latency:
  - The update is visible on gen_out one cycle after the enabling edge.
  - gen_pulse is asserted in the same cycle gen_out first shows the new generation.
- gen_count saturates at 2^CW-1; the grid keeps evolving after saturation.
- Extinct grid in RUN: next == current, so with STOP_ON_STABLE=1 the engine halts on the first tick.
- Period-2 or longer oscillators never halt.
- Reset mid-RUN takes effect on the next edge regardless of tick or commands.

Decomposition:
- Package life_pkg holds:
  - typedef enum logic [1:0] life_state_t {IDLE, PAUSE, RUN, HALT}
  - function cell_idx(r, c, COLS)
- Sub-module life_next, purely combinational:
  - parameters ROWS, COLS, WRAP
  - input grid, output next grid
  - computes the neighbour count and rule per cell via generate loops
- life_engine contains the FSM, grid register, counter, pulse register and flag compares.

Test Plan:
- Blinker: ROWS=COLS=16, WRAP=0, seed cells (5,4),(5,5),(5,6); load, run, tick every cycle -> gen_out alternates horizontal/vertical each cycle; state stays RUN; gen_count = 10 after 10 ticks.
- Block still life: seed 2x2 at (3,3); load, run, tick=1 -> HALT on first tick; gen_count = 0; stable = 1; extinct = 0; further run is ignored.
- Glider wrap: ROWS=COLS=8, WRAP=1, glider seed; 32 steps in PAUSE -> gen_out equals seed; gen_count = 32; 32 gen_pulse pulses. Same test with WRAP=0 -> the glider degenerates to a stable block, and a subsequent run halts.
- Priority: load and clear in the same cycle -> IDLE, grid 0. pause and step together in PAUSE -> no update. run with tick=0 for 5 cycles -> gen_count unchanged.
- Saturation: CW=3, blinker, 10 ticks -> gen_count holds 7 while gen_out keeps toggling.
- Reset mid-RUN after 4 generations -> next cycle gen_out = 0, gen_count = 0, state IDLE, gen_pulse = 0.
